matrix_3x3_8bit_gen: RTL and testbench
======================================

Name: matrix_3x3_8bit_gen

Overview:
- Builds the 3x3 neighbourhood window for the spatial filters (Sobel, median, erosion/dilation) in the plate-recognition image pipeline.
- Sits directly downstream of the two-line 8-bit shift RAM. It instantiates that RAM, feeds it the current-line pixel, and consumes its two delayed-row taps.
- Registers three columns per row and emits nine aligned pixels with matching sync signals.
- Handles zero-padding at frame and line borders.

Parameters:
- IMG_W_MAX, 1024, maximum active pixels per line (line RAM depth); lines longer than this are unsupported.
- ROW_CNT_W, 11, width of the internal row counter.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- per_frame_vsync  in  1  input frame sync, active high
- per_frame_href  in  1  input line valid, active high
- per_frame_clken  in  1  input pixel strobe, one pixel per high cycle, only while href=1
- per_img_y  in  8  input grey pixel
- matrix_frame_vsync  out  1  vsync delayed to match the window
- matrix_frame_href  out  1  href delayed to match the window
- matrix_frame_clken  out  1  strobe marking a valid window
- matrix_p11,p12,p13  out  8 each  row r-2, columns c-2,c-1,c
- matrix_p21,p22,p23  out  8 each  row r-1, columns c-2,c-1,c
- matrix_p31,p32,p33  out  8 each  row r, columns c-2,c-1,c

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all outputs 0;
  - all window registers, sync delay registers and the row counter cleared.
  - Line RAM contents are don't-care.
- Line RAM hookup:
  - shiftin = per_img_y; clken = per_frame_clken; per_frame_href passed through.
  - taps0x = row r-1 and taps1x = row r-2, each valid one cycle after the strobe for pixel (r,c).
  - per_img_y is registered once so all three rows are aligned in cycle T+1.
- Row counter:
  - cleared on the vsync rising edge;
  - increments on each href falling edge;
  - saturates at all-ones.
  - row_cnt = r for the line in progress (first line of a frame is r=0).
- Row masking: at window load, row r-1 data is forced to 0 when r<1, and row r-2 data is forced to 0 when r<2. This avoids stale previous-frame RAM data.
- Column window (per row):
  - shift register p_1 <- p_2 <- p_3 <- new data;
  - shifts only in the cycle the aligned strobe (per_frame_clken delayed 1) is high;
  - holds otherwise.
  - On the href rising edge (input, registered), all nine registers are cleared to 0, so column c-1 and c-2 read 0 for c=0 and column c-2 reads 0 for c=1.
- Latency:
  - input strobe at cycle T -> window containing pixel (r,c) at p33, with matrix_frame_clken=1, at cycle T+2.
  - vsync and href are delayed by exactly 2 cycles; matrix_frame_clken is per_frame_clken delayed by 2 cycles.
  - matrix_frame_clken is never high while matrix_frame_href=0.
- Strobe gaps: clken may be low for arbitrary cycles inside href. The window holds, and output strobes keep the same 2-cycle offset.
- Output stability: window outputs change only in the cycle after a shift. They hold between strobes and after href falls until the next href rising edge clears them.
- Simultaneous vsync rise and href fall: the counter clear wins (row_cnt=0).
- Reset mid-frame: everything clears immediately. The first frame after reset release is treated as starting with r=0 once vsync rises. Data before the first vsync rise is processed with row_cnt=0 (both upper rows masked).
- Line length: a line longer than IMG_W_MAX wraps the RAM address. This is not detected; it is out of scope.

Test Plan:
- Reset: hold rst_n=0 mid-line with random pixels driving -> all outputs 0 asynchronously; after release, first window has p11..p23 = 0.
- Single 4x4 ramp frame (pixel = 16*r + c), continuous clken:
  - at r=2, c=2 -> p11..p33 = 0,1,2,16,17,18,32,33,34;
  - matrix_frame_clken rises exactly 2 cycles after the input strobe.
- Borders, same frame:
  - r=0, c=0 -> only p33=0x00 nonzero-capable (all others 0);
  - r=1, c=1 -> p21=0, p22=0x00, p23=0x01, p31=0, p32=0x10, p33=0x11; row 1 all 0.
- Gapped strobe: clken pattern 1,0,0,1,1,0,1 on an 8-wide line, row 2 of a ramp -> window contents match the ramp for each strobe; outputs hold during gaps; strobe offset stays 2.
- Two consecutive frames, second frame ramp + 0x80 -> second frame's r=0 and r=1 windows show no first-frame data in the upper rows (masked to 0).
- Sync alignment: random href/vsync widths over 3 frames -> matrix_frame_vsync/href equal the inputs delayed by 2 cycles bit-exact; no output strobe outside href.

Source files
------------

// File: rtl/matrix_3x3_8bit_gen.sv
// 3x3 neighbourhood window generator with a built-in two-line 8-bit shift RAM.
// Emits nine aligned pixels two cycles after each input strobe, zero-padded at borders.

module matrix_3x3_line_ram #(
  parameter int DEPTH = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken,
  input  logic       href,
  input  logic [7:0] shiftin,
  output logic [7:0] taps0x,
  output logic [7:0] taps1x
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Each word holds {row r-1, row r-2} for one column.
  logic [15:0]   mem [DEPTH];
  logic [15:0]   rd_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] wr_addr_q;
  logic          wr_en_q;
  logic [7:0]    wr_pix_q;

  always_comb begin
    addr_d = addr_q;
    if (!href) begin
      addr_d = '0;
    end else if (clken) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_pix_q  <= '0;
    end else begin
      addr_q    <= addr_d;
      wr_en_q   <= clken;
      wr_addr_q <= addr_q;
      wr_pix_q  <= shiftin;
    end
  end

  // Write-back lags the read by one cycle so the old row r-1 comes from the registered read.
  always_ff @(posedge clk) begin
    if (clken) begin
      rd_q <= mem[addr_q];
    end
    if (wr_en_q) begin
      mem[wr_addr_q] <= {wr_pix_q, rd_q[15:8]};
    end
  end

  assign taps0x = rd_q[15:8];
  assign taps1x = rd_q[7:0];
endmodule

module matrix_3x3_8bit_gen #(
  parameter int IMG_W_MAX = 1024,
  parameter int ROW_CNT_W = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_y,
  output logic       matrix_frame_vsync,
  output logic       matrix_frame_href,
  output logic       matrix_frame_clken,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33
);
  logic [7:0] taps0;
  logic [7:0] taps1;

  matrix_3x3_line_ram #(
    .DEPTH(IMG_W_MAX)
  ) u_line_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .clken  (per_frame_clken),
    .href   (per_frame_href),
    .shiftin(per_img_y),
    .taps0x (taps0),
    .taps1x (taps1)
  );

  logic                 vsync_d1_q, href_d1_q, clken_d1_q;
  logic                 vsync_d2_q, href_d2_q, clken_d2_q;
  logic                 clken_d1_d;
  logic [7:0]           pix_q;
  logic [ROW_CNT_W-1:0] row_cnt_q;
  logic [ROW_CNT_W-1:0] row_cnt_d;
  logic [7:0]           win_q [3][3];
  logic [7:0]           win_d [3][3];
  logic [7:0]           row_new [3];
  logic                 vsync_rise, href_rise, href_fall;

  assign vsync_rise = per_frame_vsync & ~vsync_d1_q;
  assign href_rise  = per_frame_href & ~href_d1_q;
  assign href_fall  = ~per_frame_href & href_d1_q;
  assign clken_d1_d = per_frame_clken & per_frame_href;

  always_comb begin
    row_cnt_d = row_cnt_q;
    if (vsync_rise) begin
      row_cnt_d = '0;
    end else if (href_fall && (row_cnt_q != '1)) begin
      row_cnt_d = row_cnt_q + 1'b1;
    end
  end

  // Upper rows are masked until the RAM holds lines of the current frame.
  always_comb begin
    row_new[0] = (row_cnt_q >= ROW_CNT_W'(2)) ? taps1 : 8'd0;
    row_new[1] = (row_cnt_q != '0) ? taps0 : 8'd0;
    row_new[2] = pix_q;
    win_d = win_q;
    if (href_rise) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_d[r][c] = 8'd0;
        end
      end
    end else if (clken_d1_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        win_d[r][2] = row_new[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q <= 1'b0;
      href_d1_q  <= 1'b0;
      clken_d1_q <= 1'b0;
      vsync_d2_q <= 1'b0;
      href_d2_q  <= 1'b0;
      clken_d2_q <= 1'b0;
      pix_q      <= '0;
      row_cnt_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      vsync_d1_q <= per_frame_vsync;
      href_d1_q  <= per_frame_href;
      clken_d1_q <= clken_d1_d;
      vsync_d2_q <= vsync_d1_q;
      href_d2_q  <= href_d1_q;
      clken_d2_q <= clken_d1_q;
      pix_q      <= per_img_y;
      row_cnt_q  <= row_cnt_d;
      win_q      <= win_d;
    end
  end

  assign matrix_frame_vsync = vsync_d2_q;
  assign matrix_frame_href  = href_d2_q;
  assign matrix_frame_clken = clken_d2_q;

  assign matrix_p11 = win_q[0][0];
  assign matrix_p12 = win_q[0][1];
  assign matrix_p13 = win_q[0][2];
  assign matrix_p21 = win_q[1][0];
  assign matrix_p22 = win_q[1][1];
  assign matrix_p23 = win_q[1][2];
  assign matrix_p31 = win_q[2][0];
  assign matrix_p32 = win_q[2][1];
  assign matrix_p33 = win_q[2][2];
endmodule

// File: tb/tb_matrix_3x3_8bit_gen.sv
// Bench for matrix_3x3_8bit_gen: image-array reference model, delayed-sync history,
// hand-computed ramp windows, and directed reset / gap / multi-frame sequences.

module tb_matrix_3x3_8bit_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic       clken = 1'b0;
  logic [7:0] y = 8'd0;
  logic       o_vsync, o_href, o_clken;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [71:0] act_win;

  matrix_3x3_8bit_gen dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .per_frame_vsync   (vsync),
    .per_frame_href    (href),
    .per_frame_clken   (clken),
    .per_img_y         (y),
    .matrix_frame_vsync(o_vsync),
    .matrix_frame_href (o_href),
    .matrix_frame_clken(o_clken),
    .matrix_p11        (p11),
    .matrix_p12        (p12),
    .matrix_p13        (p13),
    .matrix_p21        (p21),
    .matrix_p22        (p22),
    .matrix_p23        (p23),
    .matrix_p31        (p31),
    .matrix_p32        (p32),
    .matrix_p33        (p33)
  );

  assign act_win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

  initial forever #5 clk = ~clk;

  typedef struct {
    int          r;
    int          c;
    logic [71:0] win;
  } win_t;

  win_t        exp_q[$];
  int          rd_idx;
  logic [7:0]  img [16][16];
  logic [71:0] cap [16][16];
  bit          cap_ok [16][16];
  int          n_vec, n_err;
  bit          mon_en;
  logic [2:0]  hist1, hist2;
  logic [71:0] prev_win;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got nothing expected an output window", name);
  endtask

  // Window straight from the image: anything above or left of the frame is zero.
  function automatic logic [71:0] model_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int rr;
        int cc;
        rr = r - 2 + i;
        cc = c - 2 + j;
        w = {w[63:0], ((rr >= 0) && (cc >= 0)) ? img[rr][cc] : 8'h00};
      end
    end
    return w;
  endfunction

  task automatic monitor();
    logic [71:0] e;
    if (!rst_n || !mon_en) begin
      hist1 = '0;
      hist2 = '0;
      prev_win = '0;
      return;
    end
    chk("sync_delay2", {69'd0, o_vsync, o_href, o_clken}, {69'd0, hist2});
    if (o_clken) begin
      chk("strobe_in_href", {71'd0, o_href}, 72'd1);
      if (rd_idx >= exp_q.size()) begin
        fail_msg("unexpected_strobe");
      end else begin
        e = exp_q[rd_idx].win;
        chk($sformatf("win_r%0d_c%0d", exp_q[rd_idx].r, exp_q[rd_idx].c), act_win, e);
        cap[exp_q[rd_idx].r][exp_q[rd_idx].c] = act_win;
        cap_ok[exp_q[rd_idx].r][exp_q[rd_idx].c] = 1'b1;
        rd_idx++;
      end
    end else begin
      e = (hist1[1] && !hist2[1]) ? 72'd0 : prev_win;
      chk("hold_or_clear", act_win, e);
    end
    prev_win = act_win;
    hist2 = hist1;
    hist1 = {vsync, href, clken};
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cap_ok[r][c] = 1'b0;
        cap[r][c] = '0;
      end
    end
  endtask

  task automatic drive_line(input int r, input int w, input bit ramp, input logic [7:0] base,
                            input int gap_mode, input int idle);
    logic [0:6] pat;
    int         c;
    int         k;
    bit         en;
    logic [7:0] px;
    win_t       e;
    pat = 7'b1001101;
    c = 0;
    k = 0;
    href = 1'b1;
    while (c < w) begin
      case (gap_mode)
        0:       en = 1'b1;
        1:       en = pat[k % 7];
        default: en = ($urandom_range(0, 2) != 0);
      endcase
      k++;
      if (en) begin
        px = ramp ? 8'(int'(base) + 16 * r + c) : 8'($urandom);
        img[r][c] = px;
        e.r = r;
        e.c = c;
        e.win = model_win(r, c);
        exp_q.push_back(e);
        clken = 1'b1;
        y = px;
        c++;
      end else begin
        clken = 1'b0;
        y = 8'($urandom);
      end
      step();
    end
    clken = 1'b0;
    href = 1'b0;
    y = 8'd0;
    repeat (idle) step();
  endtask

  task automatic drive_frame(input int w, input int h, input bit ramp, input logic [7:0] base,
                             input int gap_mode, input int last_idle);
    vsync = 1'b1;
    repeat ($urandom_range(1, 4)) step();
    vsync = 1'b0;
    repeat ($urandom_range(1, 3)) step();
    for (int r = 0; r < h; r++) begin
      drive_line(r, w, ramp, base, gap_mode, (r == h - 1) ? last_idle : $urandom_range(1, 3));
    end
    $display("frame %0dx%0d ramp=%0d base=%02h gap_mode=%0d driven", w, h, ramp, base, gap_mode);
  endtask

  initial begin
    win_t tbl [7];
    n_vec = 0;
    n_err = 0;
    rd_idx = 0;
    mon_en = 1'b0;
    hist1 = '0;
    hist2 = '0;
    prev_win = '0;
    clear_cap();

    tbl[0] = '{0, 0, 72'h00_00_00_00_00_00_00_00_00};
    tbl[1] = '{0, 3, 72'h00_00_00_00_00_00_01_02_03};
    tbl[2] = '{1, 1, 72'h00_00_00_00_00_01_00_10_11};
    tbl[3] = '{2, 0, 72'h00_00_00_00_00_10_00_00_20};
    tbl[4] = '{2, 2, 72'h00_01_02_10_11_12_20_21_22};
    tbl[5] = '{3, 1, 72'h00_10_11_00_20_21_00_30_31};
    tbl[6] = '{3, 3, 72'h11_12_13_21_22_23_31_32_33};

    repeat (3) step();
    chk("reset_window", act_win, 72'd0);
    chk("reset_sync", {69'd0, o_vsync, o_href, o_clken}, 72'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();
    step();

    // 4x4 ramp, continuous strobe, checked against hand-computed windows.
    drive_frame(4, 4, 1'b1, 8'h00, 0, 3);
    repeat (4) step();
    for (int i = 0; i < 7; i++) begin
      if (!cap_ok[tbl[i].r][tbl[i].c]) begin
        fail_msg($sformatf("ramp_table_r%0d_c%0d", tbl[i].r, tbl[i].c));
      end else begin
        chk($sformatf("ramp_table_r%0d_c%0d", tbl[i].r, tbl[i].c), cap[tbl[i].r][tbl[i].c], tbl[i].win);
      end
    end

    // Gapped strobe 1,0,0,1,1,0,1 on an 8-wide ramp.
    drive_frame(8, 3, 1'b1, 8'h00, 1, 3);

    // Two frames; vsync of the second rises with the first's last href fall.
    drive_frame(4, 3, 1'b1, 8'h00, 0, 0);
    clear_cap();
    drive_frame(4, 3, 1'b1, 8'h80, 0, 3);
    repeat (3) step();
    chk("f2_r0_upper_rows", {24'd0, cap[0][2][71:24]}, 72'd0);
    chk("f2_r1_top_row", {48'd0, cap[1][2][71:48]}, 72'd0);
    chk("f2_r1_mid_row", {48'd0, cap[1][2][47:24]}, 72'h808182);

    // Asynchronous reset in the middle of a line.
    mon_en = 1'b0;
    href = 1'b1;
    repeat (4) begin
      clken = 1'b1;
      y = 8'($urandom);
      step();
    end
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_window", act_win, 72'd0);
    chk("async_reset_sync", {69'd0, o_vsync, o_href, o_clken}, 72'd0);
    repeat (3) begin
      y = 8'($urandom);
      step();
    end
    chk("held_reset_window", act_win, 72'd0);
    href = 1'b0;
    clken = 1'b0;
    step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    clear_cap();
    drive_line(0, 5, 1'b0, 8'h00, 2, 3);
    repeat (3) step();
    if (!cap_ok[0][0]) begin
      fail_msg("post_reset_first_window");
    end else begin
      chk("post_reset_upper_rows", {24'd0, cap[0][0][71:24]}, 72'd0);
    end

    // Random sync widths, random gaps and pixels over three frames.
    for (int f = 0; f < 3; f++) begin
      drive_frame($urandom_range(3, 12), $urandom_range(2, 5), 1'b0, 8'h00, 2, $urandom_range(0, 3));
    end
    repeat (5) step();
    chk("all_windows_emitted", 72'(rd_idx), 72'(exp_q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
